// File: rtl/methane_pkg.sv
// Shared types for the methane core memory stage: memory op encoding, LSU states,
// read-latency bounds and small op classification helpers.
package methane_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Halfwords need a[0]=0, words need a[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      LH, LHU, SH: mis = addr_lo[0];
      LW, SW:      mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-BRAM signals of the load/store unit.
// slave is the LSU side; master is the execute stage / BRAM side.
interface lsu_if;
  logic                 req_valid;
  logic                 req_ready;
  methane_pkg::mem_op_t req_op;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [4:0]           req_rd;

  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic [4:0]           resp_rd;
  logic                 resp_misalign;

  logic [31:0]          mem_addr;
  logic [31:0]          mem_din;
  logic [3:0]           mem_we;
  logic [31:0]          mem_dout;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_misalign,
    output mem_addr, mem_din, mem_we
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_misalign,
    input  mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/lsu_load_format.sv
// Combinational load extract/extend: picks the addressed byte or halfword out of the
// BRAM word and sign- or zero-extends it. Stores produce 0.
module lsu_load_format
  import methane_pkg::*;
(
  input  logic [31:0] dout,
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = dout[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[addr_lo];
  // Halfword selection deliberately ignores addr_lo[0].
  assign half_sel = addr_lo[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  always_comb begin
    data = '0;
    case (op)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'd0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'd0, half_sel};
      LW:      data = dout;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one in-flight data-BRAM access, byte-lane stores, extended loads.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of masking.
module lsu
  import methane_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input logic  clk,
  input logic  rstn,
  lsu_if.slave bus
);

  localparam int RL = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                      (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;
  localparam logic [1:0] WAIT_INIT = 2'(RL - 1);

  lsu_state_t  state_reg;
  mem_op_t     op_reg;
  logic [1:0]  addr_lo_reg;
  logic [4:0]  rd_reg;
  logic        trap_reg;
  logic [1:0]  wait_cnt_reg;
  logic        req_ready_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_din_reg;
  logic [3:0]  mem_we_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic [4:0]  resp_rd_reg;
  logic        resp_misalign_reg;

  logic        trap_next;
  logic [3:0]  store_we_next;
  logic [31:0] store_din_next;
  logic [31:0] load_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_next = is_misaligned(bus.req_op, bus.req_addr[1:0]);
`else
  assign trap_next = 1'b0;
`endif

  always_comb begin
    store_we_next  = 4'b0000;
    store_din_next = bus.req_wdata;
    case (bus.req_op)
      SB: begin
        store_we_next  = 4'b0001 << bus.req_addr[1:0];
        store_din_next = {4{bus.req_wdata[7:0]}};
      end
      SH: begin
        store_we_next  = 4'b0011 << {bus.req_addr[1], 1'b0};
        store_din_next = {2{bus.req_wdata[15:0]}};
      end
      SW:      store_we_next = 4'b1111;
      default: store_we_next = 4'b0000;
    endcase
    if (trap_next) begin
      store_we_next = 4'b0000;
    end
  end

  lsu_load_format u_load_format (
    .dout    (bus.mem_dout),
    .op      (op_reg),
    .addr_lo (addr_lo_reg),
    .data    (load_data)
  );

  // WAIT spans RL cycles; the edge leaving WAIT is the one that captures mem_dout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg         <= IDLE;
      op_reg            <= LB;
      addr_lo_reg       <= 2'b00;
      rd_reg            <= 5'd0;
      trap_reg          <= 1'b0;
      wait_cnt_reg      <= 2'b00;
      req_ready_reg     <= 1'b1;
      mem_addr_reg      <= 32'd0;
      mem_din_reg       <= 32'd0;
      mem_we_reg        <= 4'b0000;
      resp_valid_reg    <= 1'b0;
      resp_rdata_reg    <= 32'd0;
      resp_rd_reg       <= 5'd0;
      resp_misalign_reg <= 1'b0;
    end else begin
      mem_we_reg     <= 4'b0000;
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid && req_ready_reg) begin
            state_reg     <= ISSUE;
            req_ready_reg <= 1'b0;
            op_reg        <= bus.req_op;
            addr_lo_reg   <= bus.req_addr[1:0];
            rd_reg        <= bus.req_rd;
            trap_reg      <= trap_next;
            mem_addr_reg  <= {bus.req_addr[31:2], 2'b00};
            mem_din_reg   <= store_din_next;
            mem_we_reg    <= store_we_next;
          end
        end
        ISSUE: begin
          if (is_store(op_reg) || trap_reg) begin
            state_reg         <= RESP;
            resp_valid_reg    <= 1'b1;
            resp_rdata_reg    <= 32'd0;
            resp_rd_reg       <= trap_reg ? rd_reg : 5'd0;
            resp_misalign_reg <= trap_reg;
          end else begin
            state_reg    <= WAIT;
            wait_cnt_reg <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 2'b00) begin
            state_reg         <= RESP;
            resp_valid_reg    <= 1'b1;
            resp_rdata_reg    <= load_data;
            resp_rd_reg       <= rd_reg;
            resp_misalign_reg <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end
        RESP: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_reg;
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.mem_din       = mem_din_reg;
  assign bus.mem_we        = mem_we_reg;
  assign bus.resp_valid    = resp_valid_reg;
  assign bus.resp_rdata    = resp_rdata_reg;
  assign bus.resp_rd       = resp_rd_reg;
  assign bus.resp_misalign = resp_misalign_reg;

endmodule
